cookie_ctrl: RTL

COOKIE_CTRL -- requirements
Module: cookie_ctrl

---
 rtl/cookie_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/cookie_ctrl.sv
// Cookie chain controller: serialises a seed word MSB-first into the chain and
// captures the returned bits once the chain latency has elapsed.
module cookie_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CHAIN_LAT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic             rbit_i,
  output logic             en,
  output logic             rbit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int            RUN_LEN   = CHAIN_LAT + WIDTH;
  localparam int            CW        = $clog2(RUN_LEN);
  localparam logic [CW-1:0] LAST      = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0] CAP_FIRST = CW'(CHAIN_LAT);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [WIDTH-1:0] TOP    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cyc;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-2:0] cap;

  logic [CW-1:0]    cyc_nxt;
  logic             rbit_nxt;
  logic [WIDTH-1:0] cap_shift;

  // Capture keeps only WIDTH-1 bits; the final bit joins it on the way to result.
  always_comb begin
    cyc_nxt   = cyc + ONE;
    rbit_nxt  = |(seed_reg & (TOP >> cyc_nxt));
    cap_shift = {cap, rbit_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc      <= '0;
      seed_reg <= '0;
      cap      <= '0;
      result   <= '0;
      en       <= 1'b0;
      rbit     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            seed_reg <= seed;
            cyc      <= '0;
            state    <= RUN;
            en       <= 1'b1;
            rbit     <= seed[WIDTH-1];
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            cyc   <= '0;
            en    <= 1'b0;
            rbit  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            if (cyc >= CAP_FIRST) cap <= cap_shift[WIDTH-2:0];
            if (cyc == LAST) begin
              state  <= DONE;
              cyc    <= '0;
              en     <= 1'b0;
              rbit   <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= cap_shift;
            end else begin
              cyc  <= cyc_nxt;
              rbit <= rbit_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
